// File: rtl/cps_lane_scheduler.sv
// Two-lane entrance scheduler: round-robin access to one shared password checker,
// per-lane gate control and lot occupancy tracking.
module cps_lane_scheduler #(
    parameter int unsigned CAPACITY    = 16,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned CHK_TIMEOUT = 64,
    parameter int unsigned GATE_HOLD   = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       lane_req,
    input  logic [1:0]       car_in,
    input  logic             car_out,
    input  logic             chk_done,
    input  logic             chk_ok,
    output logic             chk_start,
    output logic             chk_lane,
    output logic [1:0]       grant,
    output logic [1:0]       gate_open,
    output logic             deny,
    output logic [CNT_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    localparam int unsigned TMR_MAX = (CHK_TIMEOUT > GATE_HOLD) ? CHK_TIMEOUT : GATE_HOLD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        OPEN  = 2'd2,
        DENY  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             last_q, last_d;
    logic             win;
    logic             car_acc;
    logic             chk_start_d, chk_lane_d, deny_d, full_d, empty_d;
    logic [1:0]       grant_d, gate_d;
    logic [CNT_W-1:0] occ_d;

    // State, timer, round-robin pointer and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            last_q    <= 1'b1;
            chk_start <= 1'b0;
            chk_lane  <= 1'b0;
            grant     <= 2'b00;
            gate_open <= 2'b00;
            deny      <= 1'b0;
            occupancy <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            last_q    <= last_d;
            chk_start <= chk_start_d;
            chk_lane  <= chk_lane_d;
            grant     <= grant_d;
            gate_open <= gate_d;
            deny      <= deny_d;
            occupancy <= occ_d;
            full      <= full_d;
            empty     <= empty_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        last_d      = last_q;
        win         = 1'b0;
        car_acc     = 1'b0;
        chk_start_d = 1'b0;
        chk_lane_d  = chk_lane;
        grant_d     = grant;
        gate_d      = gate_open;
        deny_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!full && (lane_req != 2'b00)) begin
                    // On contention the lane not served last wins
                    win         = (lane_req == 2'b11) ? ~last_q : lane_req[1];
                    state_d     = CHECK;
                    chk_start_d = 1'b1;
                    chk_lane_d  = win;
                    grant_d     = win ? 2'b10 : 2'b01;
                    last_d      = win;
                    timer_d     = '0;
                end
            end
            CHECK: begin
                timer_d = timer_q + TMR_W'(1);
                if (chk_done) begin
                    if (chk_ok) begin
                        state_d = OPEN;
                        gate_d  = grant;
                        timer_d = '0;
                    end else begin
                        state_d = DENY;
                        deny_d  = 1'b1;
                    end
                end else if (timer_q == TMR_W'(CHK_TIMEOUT - 1)) begin
                    state_d = DENY;
                    deny_d  = 1'b1;
                end
            end
            OPEN: begin
                timer_d = timer_q + TMR_W'(1);
                if (car_in[chk_lane]) begin
                    car_acc = 1'b1;
                    state_d = IDLE;
                    gate_d  = 2'b00;
                    grant_d = 2'b00;
                end else if (timer_q == TMR_W'(GATE_HOLD - 1)) begin
                    state_d = IDLE;
                    gate_d  = 2'b00;
                    grant_d = 2'b00;
                end
            end
            DENY: begin
                state_d = IDLE;
                grant_d = 2'b00;
                timer_d = '0;
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
                gate_d  = 2'b00;
            end
        endcase
    end

    // Saturating occupancy; a simultaneous entry and exit cancel out
    always_comb begin
        occ_d = occupancy;
        if (car_acc && !car_out) begin
            if (occupancy < CNT_W'(CAPACITY)) begin
                occ_d = occupancy + CNT_W'(1);
            end
        end else if (car_out && !car_acc) begin
            if (occupancy != '0) begin
                occ_d = occupancy - CNT_W'(1);
            end
        end
        full_d  = (occ_d == CNT_W'(CAPACITY));
        empty_d = (occ_d == '0);
    end

endmodule

// File: tb/tb_cps_lane_scheduler.sv
// Directed self-checking bench for cps_lane_scheduler with hand-computed expectations.
module tb_cps_lane_scheduler;

    logic       clk;
    logic       reset_n;
    logic [1:0] lane_req;
    logic [1:0] car_in;
    logic       car_out;
    logic       chk_done;
    logic       chk_ok;
    logic       chk_start;
    logic       chk_lane;
    logic [1:0] grant;
    logic [1:0] gate_open;
    logic       deny;
    logic [7:0] occupancy;
    logic       full;
    logic       empty;

    int n_checks = 0;
    int n_errors = 0;

    cps_lane_scheduler #(
        .CAPACITY(16), .CNT_W(8), .CHK_TIMEOUT(64), .GATE_HOLD(200)
    ) dut (
        .clk(clk), .reset_n(reset_n), .lane_req(lane_req), .car_in(car_in),
        .car_out(car_out), .chk_done(chk_done), .chk_ok(chk_ok),
        .chk_start(chk_start), .chk_lane(chk_lane), .grant(grant),
        .gate_open(gate_open), .deny(deny), .occupancy(occupancy),
        .full(full), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        reset_n  = 1'b0;
        lane_req = 2'b00;
        car_in   = 2'b00;
        car_out  = 1'b0;
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One full successful attempt from IDLE with lane_req already driven
    task automatic do_pass(input logic [1:0] exp_grant, input logic [7:0] exp_occ);
        tick;
        check("pass_grant", grant, exp_grant);
        check("pass_start", chk_start, 1'b1);
        check("pass_lane", chk_lane, exp_grant[1]);
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        tick;
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        check("pass_gate", gate_open, exp_grant);
        car_in = exp_grant;
        tick;
        car_in = 2'b00;
        check("pass_close", gate_open, 2'b00);
        check("pass_occ", occupancy, exp_occ);
    endtask

    initial begin
        int  starts;
        bit  seen;

        // Reset values
        apply_reset;
        check("rst_grant", grant, 2'b00);
        check("rst_gate", gate_open, 2'b00);
        check("rst_start", chk_start, 1'b0);
        check("rst_deny", deny, 1'b0);
        check("rst_occ", occupancy, 8'd0);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);

        // Single lane request: start, verdict at cycle 5, entry
        tick;
        lane_req = 2'b01;
        tick;
        lane_req = 2'b00;
        check("t1_start", chk_start, 1'b1);
        check("t1_lane", chk_lane, 1'b0);
        check("t1_grant", grant, 2'b01);
        tick;
        check("t1_start_pulse", chk_start, 1'b0);
        repeat (3) tick;
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        tick;
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        check("t1_gate", gate_open, 2'b01);
        car_in = 2'b01;
        tick;
        car_in = 2'b00;
        check("t1_occ", occupancy, 8'd1);
        check("t1_gate_closed", gate_open, 2'b00);
        check("t1_empty", empty, 1'b0);

        // Both lanes held: grants alternate starting from lane0
        apply_reset;
        lane_req = 2'b11;
        do_pass(2'b01, 8'd1);
        do_pass(2'b10, 8'd2);
        do_pass(2'b01, 8'd3);
        do_pass(2'b10, 8'd4);
        lane_req = 2'b00;

        // Checker silent: deny exactly 64 cycles after chk_start
        tick;
        lane_req = 2'b01;
        tick;
        lane_req = 2'b00;
        check("to_start", chk_start, 1'b1);
        repeat (63) tick;
        check("to_deny_early", deny, 1'b0);
        tick;
        check("to_deny", deny, 1'b1);
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        tick;
        check("to_deny_pulse", deny, 1'b0);
        check("to_grant_clr", grant, 2'b00);
        tick;
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        check("to_late_gate", gate_open, 2'b00);
        check("to_late_occ", occupancy, 8'd4);
        check("to_late_start", chk_start, 1'b0);

        // Verdict on the timeout cycle wins over the timeout
        lane_req = 2'b01;
        tick;
        lane_req = 2'b00;
        check("pri_start", chk_start, 1'b1);
        repeat (63) tick;
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        tick;
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        check("pri_gate", gate_open, 2'b01);
        check("pri_deny", deny, 1'b0);
        car_in = 2'b01;
        tick;
        car_in = 2'b00;
        check("pri_occ", occupancy, 8'd5);

        // Rejected verdict
        lane_req = 2'b01;
        tick;
        lane_req = 2'b00;
        chk_done = 1'b1;
        chk_ok   = 1'b0;
        tick;
        chk_done = 1'b0;
        check("bad_deny", deny, 1'b1);
        check("bad_gate", gate_open, 2'b00);
        tick;
        check("bad_grant", grant, 2'b00);

        // Gate hold expiry; car_in on the other lane is ignored
        lane_req = 2'b01;
        tick;
        lane_req = 2'b00;
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        tick;
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        check("hold_gate", gate_open, 2'b01);
        car_in = 2'b10;
        tick;
        car_in = 2'b00;
        check("hold_wrong_lane", gate_open, 2'b01);
        repeat (198) tick;
        check("hold_last", gate_open, 2'b01);
        tick;
        check("hold_closed", gate_open, 2'b00);
        check("hold_occ", occupancy, 8'd5);

        // Fill to capacity, then full blocks new grants
        lane_req = 2'b01;
        for (int k = 6; k <= 16; k++) begin
            do_pass(2'b01, 8'(k));
        end
        check("fill_full", full, 1'b1);
        starts = 0;
        repeat (50) begin
            tick;
            starts += int'(chk_start);
        end
        check("full_block", starts, 0);
        car_out = 1'b1;
        tick;
        car_out = 1'b0;
        check("exit_occ", occupancy, 8'd15);
        check("exit_full", full, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick;
            if (chk_start) seen = 1'b1;
        end
        check("rearm_start", seen, 1'b1);
        lane_req = 2'b00;

        // Simultaneous entry and exit leaves occupancy unchanged
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        tick;
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        check("both_gate", gate_open, 2'b01);
        car_in  = 2'b01;
        car_out = 1'b1;
        tick;
        car_in  = 2'b00;
        car_out = 1'b0;
        check("both_occ", occupancy, 8'd15);
        check("both_gate_closed", gate_open, 2'b00);

        // Exit at empty saturates at zero
        apply_reset;
        tick;
        car_out = 1'b1;
        tick;
        car_out = 1'b0;
        check("sat0_occ", occupancy, 8'd0);
        check("sat0_empty", empty, 1'b1);

        // Asynchronous reset in OPEN with five cars parked
        lane_req = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            do_pass(2'b01, 8'(k));
        end
        tick;
        lane_req = 2'b00;
        chk_done = 1'b1;
        chk_ok   = 1'b1;
        tick;
        chk_done = 1'b0;
        chk_ok   = 1'b0;
        check("ar_gate_open", gate_open, 2'b01);
        check("ar_occ_before", occupancy, 8'd5);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_gate", gate_open, 2'b00);
        check("ar_grant", grant, 2'b00);
        check("ar_occ", occupancy, 8'd0);
        check("ar_empty", empty, 1'b1);
        #10;
        reset_n = 1'b1;
        tick;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
